// File: rtl/ser2par.sv
// Serial-to-parallel converter: collects LENGTH accepted serial bits into one word.
// Bit order (MSB- or LSB-first) is captured at the first bit of each word.
module ser2par #(
  parameter int LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              direct,
  input  logic              ivalid,
  input  logic              idata,
  output logic              ovalid,
  output logic [LENGTH-1:0] odata
);

  localparam int            CW   = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LENGTH-1:0] sr_q, sr_d;
  logic [LENGTH-1:0] odata_q, odata_d;
  logic              dir_q, dir_d;
  logic              ovalid_q, ovalid_d;

  logic accept;
  logic dir_eff;

  assign accept  = enable && ivalid;
  // The order of the first bit comes straight from the port; later bits use the latched copy.
  assign dir_eff = (cnt_q == '0) ? direct : dir_q;

  // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    odata_d  = odata_q;
    dir_d    = dir_q;
    ovalid_d = 1'b0;

    if (accept) begin
      dir_d = dir_eff;
      if (dir_eff) sr_d = {sr_q[LENGTH-2:0], idata};
      else         sr_d = {idata, sr_q[LENGTH-1:1]};

      if (cnt_q == LAST) begin
        cnt_d    = '0;
        odata_d  = sr_d;
        ovalid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      sr_q     <= '0;
      odata_q  <= '0;
      dir_q    <= 1'b1;
      ovalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      odata_q  <= odata_d;
      dir_q    <= dir_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign ovalid = ovalid_q;
  assign odata  = odata_q;

endmodule

// File: tb/tb_ser2par.sv
// Scoreboard bench for ser2par: a word-level model pushes expected words, a monitor
// pops them whenever ovalid is seen and checks odata holds in between.
module tb_ser2par;

  localparam int L = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         direct = 1'b1;
  logic         ivalid = 1'b0;
  logic         idata = 1'b0;
  logic         ovalid;
  logic [L-1:0] odata;

  ser2par #(.LENGTH(L)) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .direct(direct),
    .ivalid(ivalid),
    .idata (idata),
    .ovalid(ovalid),
    .odata (odata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit           bits_q[$];
  bit           model_msb = 1'b1;
  logic [L-1:0] exp_q[$];
  logic [L-1:0] exp_hold = '0;
  bit           mon_on = 1'b0;
  int           pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Word-level model: gather accepted bits, then place bit i at position i or L-1-i.
  task automatic model(input bit r, input bit en, input bit dir, input bit iv, input bit d);
    logic [L-1:0] w;
    if (r) begin
      bits_q.delete();
      model_msb = 1'b1;
      exp_hold  = '0;
    end else if (en && iv) begin
      if (bits_q.size() == 0) model_msb = dir;
      bits_q.push_back(d);
      if (bits_q.size() == L) begin
        w = '0;
        for (int i = 0; i < L; i++) begin
          if (model_msb) w[L-1-i] = bits_q[i];
          else           w[i]     = bits_q[i];
        end
        exp_q.push_back(w);
        exp_hold = w;
        bits_q.delete();
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit dir, input bit iv, input bit d);
    reset  = r;
    enable = en;
    direct = dir;
    ivalid = iv;
    idata  = d;
    @(posedge clock);
    model(r, en, dir, iv, d);
    @(negedge clock);
  endtask

  // Monitor: pops expected words on ovalid, otherwise checks that odata holds.
  initial begin
    logic [L-1:0] w;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        if (ovalid) begin
          pulses++;
          if (exp_q.size() == 0) begin
            check("spurious_ovalid", 64'(ovalid), 64'd0);
          end else begin
            w = exp_q.pop_front();
            check("word", 64'(odata), 64'(w));
          end
        end else begin
          check("missing_ovalid", 64'(exp_q.size()), 64'd0);
          exp_q.delete();
          check("odata_hold", 64'(odata), 64'(exp_hold));
        end
      end
    end
  end

  initial begin
    logic [7:0] ab;
    logic [7:0] w3c;
    int         p0;
    ab  = 8'hAB;
    w3c = 8'h3C;

    step(1, 0, 1, 0, 0);
    mon_on = 1'b1;
    check("reset_ovalid", 64'(ovalid), 64'd0);
    check("reset_odata", 64'(odata), 64'd0);

    // MSB-first AB, then idle
    p0 = pulses;
    for (int i = 7; i >= 0; i--) step(0, 1, 1, 1, ab[i]);
    repeat (3) step(0, 1, 1, 0, 0);
    check("msb_pulses", 64'(pulses - p0), 64'd1);
    check("msb_hold", 64'(odata), 64'hAB);

    // Same stream LSB-first gives D5; direct flips mid-word must be ignored
    p0 = pulses;
    for (int i = 7; i >= 0; i--) step(0, 1, (i == 7) ? 1'b0 : 1'b1, 1, ab[i]);
    step(0, 1, 1, 0, 0);
    check("lsb_pulses", 64'(pulses - p0), 64'd1);
    check("lsb_word", 64'(odata), 64'hD5);

    // Gaps between bits
    p0 = pulses;
    for (int i = 7; i >= 0; i--) begin
      step(0, 1, 1, 1, ab[i]);
      step(0, 1, 0, 0, ~ab[i]);
      if (i == 3) step(0, 1, 0, 0, 1);
    end
    check("gap_pulses", 64'(pulses - p0), 64'd1);
    check("gap_word", 64'(odata), 64'hAB);

    // enable low for 3 cycles after bit 4
    p0 = pulses;
    for (int i = 7; i >= 0; i--) begin
      step(0, 1, 1, 1, ab[i]);
      if (i == 4) repeat (3) step(0, 0, 0, 1, 1);
    end
    step(0, 1, 1, 0, 0);
    check("en_pulses", 64'(pulses - p0), 64'd1);
    check("en_word", 64'(odata), 64'hAB);

    // Reset after bit 5 discards the partial word
    p0 = pulses;
    for (int i = 7; i >= 3; i--) step(0, 1, 1, 1, ~ab[i]);
    step(1, 1, 0, 1, 1);
    check("midreset_odata", 64'(odata), 64'd0);
    for (int i = 7; i >= 0; i--) step(0, 1, 1, 1, ab[i]);
    step(0, 1, 1, 0, 0);
    check("midreset_pulses", 64'(pulses - p0), 64'd1);
    check("midreset_word", 64'(odata), 64'hAB);

    // Back-to-back AB then 3C
    p0 = pulses;
    for (int i = 7; i >= 0; i--) step(0, 1, 1, 1, ab[i]);
    check("b2b_first", 64'(odata), 64'hAB);
    for (int i = 7; i >= 0; i--) step(0, 1, 1, 1, w3c[i]);
    check("b2b_second", 64'(odata), 64'h3C);
    check("b2b_pulses", 64'(pulses - p0), 64'd2);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 85),
           1'($urandom),
           ($urandom_range(0, 99) < 75),
           1'($urandom));
    end
    repeat (2) step(0, 0, 1, 0, 0);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ser2par.md
SER2PAR -- requirements
Module: ser2par

Interface
REQ-001 Parameter LENGTH, default 8, meaning number of serial bits per parallel word (legal range 2..64).
REQ-002 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port enable  input  1  clock enable; when low, all internal state holds.
REQ-005 Port direct  input  1  bit order: 1 = MSB-first, 0 = LSB-first.
REQ-006 Port ivalid  input  1  qualifies idata for the current cycle.
REQ-007 Port idata  input  1  serial data bit.
REQ-008 Port ovalid  output  1  one-cycle pulse marking a new odata word.
REQ-009 Port odata  output  LENGTH  last completed parallel word.
REQ-010 Single clock domain; reset is synchronous and active-high; no asynchronous logic.

Function
REQ-011 A bit is accepted on a rising edge when reset=0, enable=1 and ivalid=1; no other condition shifts data.
REQ-012 Internal bit counter 0..LENGTH-1 increments per accepted bit and wraps to 0 after the LENGTH-th bit.
REQ-013 direct is latched when the first bit of a word is accepted (counter=0); changes mid-word have no effect until the next word.
REQ-014 MSB-first (direct=1): the first accepted bit of a word lands in odata[LENGTH-1], the last in odata[0].
REQ-015 LSB-first (direct=0): the first accepted bit lands in odata[0], the last in odata[LENGTH-1].
REQ-016 Assembly uses an internal shift register separate from odata; odata changes only when a word completes.
REQ-017 On the edge accepting the LENGTH-th bit, odata loads the complete word (including that bit) and ovalid registers 1.
REQ-018 Latency: odata/ovalid are valid in the cycle immediately after the edge that sampled the last bit.
REQ-019 ovalid is 1 for exactly one cycle per completed word; it registers 0 on every edge that does not complete a word, including edges with enable=0.
REQ-020 Apart from ovalid clearing, enable=0 freezes counter, shift register, latched direct and odata.
REQ-021 ivalid=0 cycles (gaps) are allowed anywhere in a word; the counter and partial word hold.
REQ-022 odata holds its value indefinitely until the next completed word.
REQ-023 Back-to-back words with ivalid continuously high produce an ovalid pulse every LENGTH cycles with no lost bits.

Reset
REQ-024 reset=1 on a rising edge sets odata=0, ovalid=0, counter=0, shift register=0, latched direct=1, regardless of enable or ivalid.
REQ-025 reset mid-word discards the partial word; the next accepted bit is bit 1 of a new word and no ovalid is produced for the discarded bits.
REQ-026 reset has priority over all other inputs on the same edge.

Verification
REQ-027 Reset one cycle, then enable=1, direct=1, ivalid=1, idata 1,0,1,0,1,0,1,1 on consecutive cycles -> one ovalid pulse after the 8th bit with odata=8'hAB; odata stays 8'hAB after ivalid drops.
REQ-028 Same stream with direct=0 -> odata=8'hD5, single ovalid pulse.
REQ-029 Same stream with ivalid=0 gap cycles inserted between bits -> odata=8'hAB, ovalid pulses only after the 8th accepted bit.
REQ-030 enable=0 for 3 cycles after bit 4, then resume -> odata=8'hAB, no ovalid while disabled, no extra bits captured.
REQ-031 reset after bit 5, then full stream 8'hAB MSB-first -> only one ovalid pulse, odata=8'hAB; odata reads 0 immediately after reset.
REQ-032 Two back-to-back words 8'hAB then 8'h3C MSB-first with ivalid held high -> ovalid pulses 8 cycles apart, odata 8'hAB then 8'h3C.
